// File: rtl/fifo_word_packer_if.sv
// Bus bundle for fifo_word_packer.
//   FIFO side : fifo_data / fifo_empty in, fifo_rd_en out (FWFT read port)
//   Sink side : out_data / out_keep / out_last / out_valid out, out_ready in
// master = the packer, slave = the surrounding FIFO + sink.
interface fifo_word_packer_if #(
  parameter int DATAWIDTH = 8,
  parameter int LANES     = 4
);
  logic [DATAWIDTH-1:0]       fifo_data;
  logic                       fifo_empty;
  logic                       fifo_rd_en;
  logic [DATAWIDTH*LANES-1:0] out_data;
  logic [LANES-1:0]           out_keep;
  logic                       out_last;
  logic                       out_valid;
  logic                       out_ready;

  modport master (
    input  fifo_data, fifo_empty, out_ready,
    output fifo_rd_en, out_data, out_keep, out_last, out_valid
  );

  modport slave (
    output fifo_data, fifo_empty, out_ready,
    input  fifo_rd_en, out_data, out_keep, out_last, out_valid
  );
endinterface

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: drains DATAWIDTH-bit entries from a first-word-fall-through
// FIFO and packs LANES of them into one word, lane 0 in the low bits.
// A flush closes a partial word early, with out_keep marking the filled lanes.
// Ports:
//   clk, reset_n  : clock, async active-low reset
//   bus (master)  : FIFO read port + valid/ready word output (see interface)
//   flush         : close the current partial word (level, sampled in FILL)
//   word_count    : words accepted by the sink, wraps
//   busy          : bytes held or a word pending

// One lane of the holding register: loads on its pop, clears on handshake.
module fifo_word_packer_lane #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic                 clr,
  input  logic [DATAWIDTH-1:0] din,
  output logic [DATAWIDTH-1:0] dout,
  output logic                 keep
);
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic                 keep_q, keep_d;

  always_comb begin
    data_d = data_q;
    keep_d = keep_q;
    if (clr) begin
      data_d = '0;
      keep_d = 1'b0;
    end else if (wr_en) begin
      data_d = din;
      keep_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      keep_q <= 1'b0;
    end else begin
      data_q <= data_d;
      keep_q <= keep_d;
    end
  end

  assign dout = data_q;
  assign keep = keep_q;
endmodule

module fifo_word_packer #(
  parameter int DATAWIDTH = 8,
  parameter int LANES     = 4,
  parameter int CNTWIDTH  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  fifo_word_packer_if.master  bus,
  input  logic                flush,
  output logic [CNTWIDTH-1:0] word_count,
  output logic                busy
);
  // One extra bit so the count can reach LANES itself.
  localparam int LCW = $clog2(LANES) + 1;

  typedef enum logic {FILL, HOLD} state_e;

  state_e                        state_q, state_d;
  logic [LCW-1:0]                lane_cnt_q, lane_cnt_d;
  logic                          last_q, last_d;
  logic [CNTWIDTH-1:0]           word_count_q, word_count_d;

  logic                          pop;
  logic                          accept;
  logic                          last_lane;
  logic [LANES-1:0][DATAWIDTH-1:0] lane_data;
  logic [LANES-1:0]              lane_keep;

  // Combinational pop; gated by reset so nothing is lost while held in reset.
  assign pop        = reset_n && (state_q == FILL) && !bus.fifo_empty;
  assign accept     = (state_q == HOLD) && bus.out_ready;
  assign last_lane  = (lane_cnt_q == LCW'(LANES - 1));

  always_comb begin
    state_d      = state_q;
    lane_cnt_d   = lane_cnt_q;
    last_d       = last_q;
    word_count_d = word_count_q;
    case (state_q)
      FILL: begin
        if (pop) lane_cnt_d = lane_cnt_q + LCW'(1);
        if (pop && last_lane) begin
          // Full word; a coincident flush still tags it as last.
          state_d = HOLD;
          last_d  = flush;
        end else if (flush && (lane_cnt_q != '0 || pop)) begin
          state_d = HOLD;
          last_d  = 1'b1;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d      = FILL;
          lane_cnt_d   = '0;
          last_d       = 1'b0;
          word_count_d = word_count_q + 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= FILL;
      lane_cnt_q   <= '0;
      last_q       <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      lane_cnt_q   <= lane_cnt_d;
      last_q       <= last_d;
      word_count_q <= word_count_d;
    end
  end

  // Holding register: lane g loads when the pop targets it, all clear on handshake.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fifo_word_packer_lane #(.DATAWIDTH(DATAWIDTH)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (pop && (lane_cnt_q == LCW'(g))),
      .clr     (accept),
      .din     (bus.fifo_data),
      .dout    (lane_data[g]),
      .keep    (lane_keep[g])
    );
  end

  assign bus.fifo_rd_en = pop;
  assign bus.out_data   = lane_data;
  assign bus.out_keep   = lane_keep;
  assign bus.out_last   = last_q;
  assign bus.out_valid  = (state_q == HOLD);
  assign word_count     = word_count_q;
  assign busy           = (lane_cnt_q != '0) || (state_q == HOLD);
endmodule

// File: tb/tb_fifo_word_packer.sv
module tb_fifo_word_packer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        ready;
  logic [15:0] word_count;
  logic [1:0]  word_count2;
  logic        busy, busy2;
  logic        flush2;

  // FWFT FIFO model: bench pushes at negedge, pops follow the main DUT.
  logic [7:0] mem [64];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  int checks = 0;
  int errors = 0;

  fifo_word_packer_if #(.DATAWIDTH(8), .LANES(4)) bus1 ();
  fifo_word_packer_if #(.DATAWIDTH(8), .LANES(4)) bus2 ();

  assign bus1.fifo_data  = mem[rd_ptr[5:0]];
  assign bus1.fifo_empty = (rd_ptr == wr_ptr);
  assign bus1.out_ready  = ready;
  assign bus2.fifo_data  = mem[rd_ptr[5:0]];
  assign bus2.fifo_empty = (rd_ptr == wr_ptr);
  assign bus2.out_ready  = ready;
  assign flush2          = flush;

  fifo_word_packer #(.DATAWIDTH(8), .LANES(4), .CNTWIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .flush(flush),
    .word_count(word_count), .busy(busy)
  );

  // Narrow-counter twin, same stream, used for the wrap check.
  fifo_word_packer #(.DATAWIDTH(8), .LANES(4), .CNTWIDTH(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .flush(flush2),
    .word_count(word_count2), .busy(busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus1.fifo_rd_en) rd_ptr <= rd_ptr + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[5:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  typedef struct {
    logic        push;
    logic [7:0]  b;
    logic        flush;
    logic        ready;
    logic        rd;     // fifo_rd_en before the edge
    logic        vld;    // outputs after the edge
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [16];

  initial begin
    // burst pack (FIFO preloaded during reset)
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000011, 4'h1, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00002211, 4'h3, 1'b0, 16'd0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00332211, 4'h7, 1'b0, 16'd0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44332211, 4'hf, 1'b0, 16'd0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 4'h0, 1'b0, 16'd1};
    // partial flush
    tbl[5]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h000000A1, 4'h1, 1'b0, 16'd1};
    tbl[6]  = '{1'b1, 8'hB2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000B2A1, 4'h3, 1'b0, 16'd1};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000B2A1, 4'h3, 1'b0, 16'd1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000B2A1, 4'h3, 1'b1, 16'd1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 4'h0, 1'b0, 16'd2};
    // empty flush ignored
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000, 4'h0, 1'b0, 16'd2};
    // pop + flush on the final lane
    tbl[11] = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000010, 4'h1, 1'b0, 16'd2};
    tbl[12] = '{1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00002010, 4'h3, 1'b0, 16'd2};
    tbl[13] = '{1'b1, 8'h30, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00302010, 4'h7, 1'b0, 16'd2};
    tbl[14] = '{1'b1, 8'h40, 1'b1, 1'b1, 1'b1, 1'b1, 32'h40302010, 4'hf, 1'b1, 16'd2};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 4'h0, 1'b0, 16'd3};

    reset_n = 1'b0;
    flush   = 1'b0;
    ready   = 1'b0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    repeat (2) @(negedge clk);

    // reset state with a non-empty FIFO
    chk("rst_rd_en", {31'd0, bus1.fifo_rd_en}, 32'd0);
    chk("rst_valid", {31'd0, bus1.out_valid}, 32'd0);
    chk("rst_data", bus1.out_data, 32'd0);
    chk("rst_keep", {28'd0, bus1.out_keep}, 32'd0);
    chk("rst_last", {31'd0, bus1.out_last}, 32'd0);
    chk("rst_cnt", {16'd0, word_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      flush = tbl[i].flush;
      ready = tbl[i].ready;
      if (tbl[i].push) push(tbl[i].b);
      #1;
      chk($sformatf("v%0d_rd_en", i), {31'd0, bus1.fifo_rd_en}, {31'd0, tbl[i].rd});
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), {31'd0, bus1.out_valid}, {31'd0, tbl[i].vld});
      chk($sformatf("v%0d_data", i), bus1.out_data, tbl[i].data);
      chk($sformatf("v%0d_keep", i), {28'd0, bus1.out_keep}, {28'd0, tbl[i].keep});
      chk($sformatf("v%0d_last", i), {31'd0, bus1.out_last}, {31'd0, tbl[i].last});
      chk($sformatf("v%0d_cnt", i), {16'd0, word_count}, {16'd0, tbl[i].cnt});
      chk($sformatf("v%0d_cnt2", i), {30'd0, word_count2}, {30'd0, tbl[i].cnt[1:0]});
      @(negedge clk);
    end

    // backpressure: 8 bytes, sink stalls for 10 cycles
    flush = 1'b0;
    ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    repeat (4) @(negedge clk);
    chk("bp_w0_valid", {31'd0, bus1.out_valid}, 32'd1);
    chk("bp_w0_keep", {28'd0, bus1.out_keep}, 32'hf);
    chk("bp_w0_last", {31'd0, bus1.out_last}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_data", bus1.out_data, 32'h04030201);
      chk("bp_hold_valid", {31'd0, bus1.out_valid}, 32'd1);
      chk("bp_hold_rd_en", {31'd0, bus1.fifo_rd_en}, 32'd0);
      @(negedge clk);
    end
    ready = 1'b1;
    #1 chk("bp_accept_rd_en", {31'd0, bus1.fifo_rd_en}, 32'd0);
    @(negedge clk);
    chk("bp_after_valid", {31'd0, bus1.out_valid}, 32'd0);
    chk("bp_cnt4", {16'd0, word_count}, 32'd4);
    chk("wrap_cnt2_0", {30'd0, word_count2}, 32'd0);
    repeat (4) @(negedge clk);
    chk("bp_w1_valid", {31'd0, bus1.out_valid}, 32'd1);
    chk("bp_w1_data", bus1.out_data, 32'h08070605);
    chk("bp_w1_keep", {28'd0, bus1.out_keep}, 32'hf);
    @(negedge clk);
    chk("bp_cnt5", {16'd0, word_count}, 32'd5);
    chk("wrap_cnt2_1", {30'd0, word_count2}, 32'd1);
    chk("bp_fifo_drained", {31'd0, bus1.fifo_empty}, 32'd1);

    // reset mid-word
    push(8'hE1); push(8'hE2);
    repeat (2) @(negedge clk);
    chk("mid_keep", {28'd0, bus1.out_keep}, 32'h3);
    chk("mid_data", bus1.out_data, 32'h0000E2E1);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_data", bus1.out_data, 32'd0);
    chk("arst_keep", {28'd0, bus1.out_keep}, 32'd0);
    chk("arst_valid", {31'd0, bus1.out_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_cnt", {16'd0, word_count}, 32'd0);
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    #1 chk("arst_rd_en", {31'd0, bus1.fifo_rd_en}, 32'd0);
    @(negedge clk);
    chk("arst_no_pop", {28'd0, bus1.out_keep}, 32'd0);
    reset_n = 1'b1;
    #1 chk("rel_rd_en", {31'd0, bus1.fifo_rd_en}, 32'd1);
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("post_rst_valid", {31'd0, bus1.out_valid}, 32'd1);
    chk("post_rst_data", bus1.out_data, 32'h88776655);
    chk("post_rst_last", {31'd0, bus1.out_last}, 32'd0);
    @(negedge clk);
    chk("post_rst_cnt", {16'd0, word_count}, 32'd1);
    chk("post_rst_cnt2", {30'd0, word_count2}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
